regfile_mp: RTL

Parametrised multi-port register file for the CPU datapath. It holds the general-purpose registers, the link register and the program counter, and provides N combinational read ports with write-to-read forwarding. It also has a dedicated link-write port for branch-and-link and a per-register pending-load scoreboard for hazard detection. It sits between decode (read addresses, busy marking) and writeback (result and link writes); pc_out feeds instruction fetch.

---
 rtl/regfile_mp.sv | 136 +++++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// Multi-port register file for the CPU datapath.
// Holds the general-purpose registers (including the link register) and the PC.
// Provides NUM_RD combinational read ports with write-to-read forwarding.
// Provides a dedicated link-write port.
// Keeps a pending-load scoreboard used by decode for hazard detection.
module regfile_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned NUM_RD   = 3,
  parameter int unsigned LINK_REG = 14,
  parameter logic [DATA_W-1:0] PC_RESET = '0
) (
  input  logic                       Clk,
  input  logic                       R,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       link_en,
  input  logic [DATA_W-1:0]          link_data,
  input  logic                       pc_en,
  input  logic [DATA_W-1:0]          pc_in,
  output logic [DATA_W-1:0]          pc_out,
  input  logic                       busy_set,
  input  logic [ADDR_W-1:0]          busy_addr
);

  localparam int unsigned NREGS = 2 ** ADDR_W;
  // The top index is the PC; it has no storage slot in regs_q or busy_q.
  localparam logic [ADDR_W-1:0] PcIdx   = ADDR_W'(NREGS - 1);
  localparam logic [ADDR_W-1:0] LinkIdx = ADDR_W'(LINK_REG);

  logic [DATA_W-1:0] regs_q [NREGS-1];
  logic [DATA_W-1:0] regs_d [NREGS-1];
  logic [NREGS-2:0]  busy_q;
  logic [NREGS-2:0]  busy_d;
  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] pc_d;

  // Next register contents: the writeback port is applied first.
  // The link port is applied after it, so the link port wins a collision on LINK_REG.
  always_comb begin
    regs_d = regs_q;
    for (int r = 0; r < int'(NREGS) - 1; r++) begin
      if (wr_en && (wr_addr == ADDR_W'(r))) begin
        regs_d[r] = wr_data;
      end
    end
    if (link_en) begin
      regs_d[LINK_REG] = link_data;
    end
  end

  // Next scoreboard state: completing writes clear their entry first.
  // A new load to the same destination then re-marks the entry as busy.
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < int'(NREGS) - 1; r++) begin
      if (wr_en && (wr_addr == ADDR_W'(r))) begin
        busy_d[r] = 1'b0;
      end
      if (link_en && (LinkIdx == ADDR_W'(r))) begin
        busy_d[r] = 1'b0;
      end
      if (busy_set && (busy_addr == ADDR_W'(r))) begin
        busy_d[r] = 1'b1;
      end
    end
  end

  // PC loads only through pc_en/pc_in; it stalls otherwise.
  always_comb begin
    pc_d = pc_q;
    if (pc_en) begin
      pc_d = pc_in;
    end
  end

  // Storage update with asynchronous clear.
  always_ff @(posedge Clk or negedge R) begin
    if (!R) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
      pc_q   <= PC_RESET;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      pc_q   <= pc_d;
    end
  end

  assign pc_out = pc_q;

  for (genvar i = 0; i < int'(NUM_RD); i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] stored;
    logic              stored_busy;
    logic [DATA_W-1:0] data;
    logic              busy;

    assign addr = rd_addr[i*ADDR_W +: ADDR_W];

    // Select the stored value and the scoreboard bit for this port's index.
    always_comb begin
      stored      = '0;
      stored_busy = 1'b0;
      for (int r = 0; r < int'(NREGS) - 1; r++) begin
        if (addr == ADDR_W'(r)) begin
          stored      = regs_q[r];
          stored_busy = busy_q[r];
        end
      end
    end

    // Forwarding priority: PC (not bypassed), then link write, then writeback, then storage.
    // A write completing this cycle cancels the pending-load hazard.
    always_comb begin
      data = stored;
      busy = stored_busy && !(wr_en && (wr_addr == addr)) && !(link_en && (addr == LinkIdx));
      if (addr == PcIdx) begin
        data = pc_q;
        busy = 1'b0;
      end else if (link_en && (addr == LinkIdx)) begin
        data = link_data;
      end else if (wr_en && (wr_addr == addr)) begin
        data = wr_data;
      end
    end

    assign rd_data[i*DATA_W +: DATA_W] = data;
    assign rd_busy[i]                  = busy;
  end

endmodule
